adc_avg_sampler: RTL and testbench

ADC_AVG_SAMPLER -- requirements
Module: adc_avg_sampler

---
 rtl/adc_avg_sampler.sv | 146 ++++++++++++++
 tb/tb_adc_avg_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_sampler.sv
// Averaging front end for an XADC: per trigger it runs 2^NB_AVG_LOG2 conversions, sums the
// results and reports their truncated mean. Per-conversion timeout and sticky error flags are included.
module adc_avg_sampler #(
    parameter int NB_DATA     = 12,
    parameter int NB_AVG_LOG2 = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_trigger,
    input  logic [NB_DATA-1:0] i_adc_val,
    input  logic               i_adc_eoc,
    output logic               o_adc_convst,
    output logic [NB_DATA-1:0] o_val,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    localparam int NB_ACC = NB_DATA + NB_AVG_LOG2;
    localparam int NB_CNT = NB_AVG_LOG2 + 1;
    localparam logic [NB_CNT-1:0] LAST_SAMPLE = NB_CNT'((1 << NB_AVG_LOG2) - 1);
    localparam logic [9:0]        TMO_LAST    = 10'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ACC-1:0]   acc_q, acc_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [9:0]          tmo_q, tmo_d;
    logic [NB_DATA-1:0]  val_q, val_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic                convst_q, convst_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [NB_ACC-1:0]   acc_sum_s;

    // Zero-extending the sample keeps the sum exact: 2^N full-scale samples fit in NB_ACC bits.
    assign acc_sum_s = acc_q + NB_ACC'(i_adc_val);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        val_d     = val_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q | (i_trigger & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An eoc on the terminal count wins over the timeout.
                if (i_adc_eoc) begin
                    acc_d = acc_sum_s;
                    cnt_d = cnt_q + NB_CNT'(1'b1);
                    if (cnt_q == LAST_SAMPLE) begin
                        val_d   = acc_sum_s[NB_ACC-1:NB_AVG_LOG2];
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_CONV;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the strobes leave flops
    always_comb begin
        convst_d = (state_d == ST_CONV);
        done_d   = (state_d == ST_OUT);
        busy_d   = (state_d != ST_IDLE);
    end

    // Datapath, flag and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            val_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            convst_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            val_q     <= val_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            convst_q  <= convst_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign o_adc_convst = convst_q;
    assign o_val        = val_q;
    assign o_done       = done_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_adc_avg_sampler.sv
// Directed bench for adc_avg_sampler: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares them whenever o_done is seen.
module tb_adc_avg_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_trigger = 1'b0;
    logic [11:0] i_adc_val = 12'd0;
    logic        i_adc_eoc = 1'b0;
    logic        o_adc_convst;
    logic [11:0] o_val;
    logic        o_done;
    logic        o_busy;
    logic        o_timeout;
    logic        o_overrun;

    typedef struct {
        int val;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   convst_cnt = 0;

    adc_avg_sampler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_trigger    (i_trigger),
        .i_adc_val    (i_adc_val),
        .i_adc_eoc    (i_adc_eoc),
        .o_adc_convst (o_adc_convst),
        .o_val        (o_val),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every o_done must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && o_adc_convst) convst_cnt++;
        if (rst_n && o_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("o_val", int'(o_val), e.val);
                check("o_timeout_at_done", int'(o_timeout), int'(e.tmo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_convst(input string name);
        int n = 0;
        while (!o_adc_convst && n < 100) begin
            tick();
            n++;
        end
        if (!o_adc_convst) check(name, 0, 1);
    endtask

    task automatic push_exp(input int val, input bit tmo);
        exp_t e;
        e.val = val;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // One full request; eoc comes dly cycles after each convst (dly0 for the first sample),
    // optionally with a second trigger 3 cycles after the first.
    task automatic run_req(input logic [3:0][11:0] v, input int dly0, input int dly,
                           input bit extra_trig);
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_convst("convst_wait");
            for (int k = 0; k < ((s == 0) ? dly0 : dly); k++) begin
                i_trigger = extra_trig && (s == 0) && (k == 2);
                tick();
            end
            i_trigger = 1'b0;
            i_adc_eoc = 1'b1;
            i_adc_val = v[s];
            tick();
            i_adc_eoc = 1'b0;
            i_adc_val = 12'd0;
        end
    endtask

    initial begin
        int c0, d0, n;
        logic [3:0][11:0] v;

        #12;
        check("rst_convst", int'(o_adc_convst), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_val", int'(o_val), 0);
        check("rst_timeout", int'(o_timeout), 0);
        check("rst_overrun", int'(o_overrun), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", int'(o_busy), 0);

        // Full-scale then zero samples
        v = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        push_exp(4095, 1'b0);
        run_req(v, 5, 5, 1'b0);
        tick();
        v = {12'd0, 12'd0, 12'd0, 12'd0};
        push_exp(0, 1'b0);
        run_req(v, 3, 3, 1'b0);
        tick();

        // 100..103 -> 101, with pulse counts and busy drop
        c0 = convst_cnt;
        d0 = done_cnt;
        v = {12'd103, 12'd102, 12'd101, 12'd100};
        push_exp(101, 1'b0);
        run_req(v, 5, 5, 1'b0);
        check("busy_in_out", int'(o_busy), 1);
        tick();
        check("busy_after_done", int'(o_busy), 0);
        check("convst_pulses", convst_cnt - c0, 4);
        check("done_pulses", done_cnt - d0, 1);
        check("overrun_clear", int'(o_overrun), 0);

        // Timeout: o_val keeps 101
        push_exp(101, 1'b1);
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        check("timeout_convst", int'(o_adc_convst), 1);
        n = 0;
        while (!o_done && n < 2000) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 1025);
        tick();
        check("timeout_sticky", int'(o_timeout), 1);
        v = {12'd41, 12'd30, 12'd20, 12'd10};
        push_exp(25, 1'b1);
        run_req(v, 2, 4, 1'b0);
        tick();

        // Overrun: second trigger 3 cycles after the first
        c0 = convst_cnt;
        d0 = done_cnt;
        v = {12'd4, 12'd3, 12'd2, 12'd1};
        push_exp(2, 1'b1);
        run_req(v, 5, 5, 1'b1);
        tick();
        tick();
        check("overrun_set", int'(o_overrun), 1);
        check("overrun_convst", convst_cnt - c0, 4);
        check("overrun_done", done_cnt - d0, 1);

        // Reset during WAIT after the second sample
        d0 = done_cnt;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        for (int s = 0; s < 2; s++) begin
            wait_convst("convst_wait_rst");
            tick();
            i_adc_eoc = 1'b1;
            i_adc_val = 12'd777;
            tick();
            i_adc_eoc = 1'b0;
        end
        wait_convst("convst_wait_rst");
        tick();
        tick();
        check("pre_rst_busy", int'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_val", int'(o_val), 0);
        check("mid_rst_timeout", int'(o_timeout), 0);
        check("mid_rst_overrun", int'(o_overrun), 0);
        check("mid_rst_convst", int'(o_adc_convst), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_no_done", done_cnt - d0, 0);
        check("post_rst_busy", int'(o_busy), 0);
        v = {12'd500, 12'd400, 12'd300, 12'd200};
        push_exp(350, 1'b0);
        run_req(v, 1, 2, 1'b0);
        tick();

        // eoc exactly on the timeout terminal count is a valid sample
        v = {12'd1003, 12'd1000, 12'd1000, 12'd1000};
        push_exp(1000, 1'b0);
        run_req(v, 1024, 5, 1'b0);
        tick();
        check("tc_eoc_timeout", int'(o_timeout), 0);

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
